// File: rtl/cfg_lut_array.sv
// Array of NLUT serially configured K-input LUTs. Each LUT output is either
// combinational or registered, and a new configuration commits atomically.
module cfg_lut_array #(
  parameter int K    = 3,
  parameter int NLUT = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_start,
  input  logic                cfg_valid,
  input  logic                cfg_din,
  output logic                cfg_ready,
  output logic                cfg_busy,
  output logic                cfg_done,
  input  logic                ce,
  input  logic [NLUT*K-1:0]   lut_in,
  output logic [NLUT-1:0]     lut_out
);

  localparam int TW   = 2 ** K;
  localparam int SEG  = TW + 1;
  localparam int CW   = NLUT * SEG;
  localparam int CNTW = $clog2(CW);
  localparam logic [CNTW-1:0] LAST = CNTW'(CW - 1);

  typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;

  state_t          state;
  logic [CNTW-1:0] cnt;
  // Only CW-1 bits need storing: the final bit goes straight into active.
  logic [CW-1:1]   shadow;
  logic [CW-1:0]   shadow_next;
  logic [CW-1:0]   active;
  logic [NLUT-1:0] comb;
  logic [NLUT-1:0] mode;
  logic [NLUT-1:0] q;

  assign shadow_next = {cfg_din, shadow};

  // Active is written on the last accept, so the new function and cfg_done
  // appear together in the single COMMIT cycle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      shadow    <= '0;
      active    <= '0;
      cfg_ready <= 1'b0;
      cfg_busy  <= 1'b0;
      cfg_done  <= 1'b0;
    end else begin
      cfg_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cfg_start) begin
            state     <= LOAD;
            cnt       <= '0;
            shadow    <= '0;
            cfg_ready <= 1'b1;
            cfg_busy  <= 1'b1;
          end
        end
        LOAD: begin
          if (cfg_start) begin
            cnt    <= '0;
            shadow <= '0;
          end else if (cfg_valid) begin
            shadow <= shadow_next[CW-1:1];
            if (cnt == LAST) begin
              active    <= shadow_next;
              state     <= COMMIT;
              cnt       <= '0;
              cfg_ready <= 1'b0;
              cfg_done  <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        COMMIT: begin
          state    <= IDLE;
          cfg_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    // NOTE: defaults first so no path through the block leaves a latch.
    comb = '0;
    mode = '0;
    for (int i = 0; i < NLUT; i++) begin
      mode[i] = active[i*SEG + TW];
      comb[i] = active[i*SEG + int'(lut_in[i*K +: K])];
    end
  end

  // Output flops run in every state and are never cleared on commit.
  always_ff @(posedge clk) begin
    if (!rst_n)  q <= '0;
    else if (ce) q <= comb;
  end

  assign lut_out = (mode & q) | (~mode & comb);

endmodule
